periph_bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared peripheral register bus (address, write data, write strobe, read data) behind the chip-select decoder. It lets several requesters run single register transactions on that bus one at a time: the MCU bus interface, sensor scan engines and DMA-like fillers. It arbitrates, latches the winning request, drives one bus cycle, waits the fixed peripheral read latency, then acknowledges the winner with read data.

---
 rtl/periph_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_periph_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared peripheral register bus.
// One single-cycle write or fixed-latency read per grant, acked with read data.
module periph_bus_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ADDR_W   = 14,
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_wr,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   input  logic [NUM_REQ-1:0]        req_mask,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rdata,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy,
   output logic [ADDR_W-1:0]         bus_addr,
   output logic [DATA_W-1:0]         bus_wdata,
   output logic                      bus_we,
   output logic                      bus_re,
   input  logic [DATA_W-1:0]         bus_rdata
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = 3;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       last_q, last_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                op_wr_q, op_wr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic                re_q, re_d;
   logic                busy_q, busy_d;

   logic [NUM_REQ-1:0]  elig;
   logic                win_found;
   logic [IW-1:0]       win_idx;
   int                  pos;

   // Search starts one past the last winner and wraps.
   always_comb begin
      elig      = req & req_mask;
      win_found = 1'b0;
      win_idx   = '0;
      pos       = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos = int'(last_q) + k;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         if (!win_found && elig[pos]) begin
            win_found = 1'b1;
            win_idx   = IW'(pos);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      op_wr_d = op_wr_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            if (win_found) begin
               state_d = ISSUE;
               last_d  = win_idx;
               grant_d = NUM_REQ'(1) << win_idx;
               op_wr_d = req_wr[win_idx];
               addr_d  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
               wdata_d = req_wdata[int'(win_idx)*DATA_W +: DATA_W];
               cnt_d   = CW'(READ_LAT - 1);
            end
         end
         ISSUE, WAIT: begin
            if (op_wr_q) begin
               state_d = ACK;
            end else if (cnt_q == '0) begin
               rdata_d = bus_rdata;
               state_d = ACK;
            end else begin
               cnt_d   = cnt_q - CW'(1);
               state_d = WAIT;
            end
         end
         ACK: begin
            state_d = IDLE;
            grant_d = '0;
         end
         default: state_d = IDLE;
      endcase
      // Outputs are registered copies of what the next state presents.
      we_d   = (state_d == ISSUE) && op_wr_d;
      re_d   = !op_wr_d && ((state_d == ISSUE) || (state_d == WAIT));
      busy_d = (state_d != IDLE);
      ack_d  = (state_d == ACK) ? grant_q : '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         last_q  <= IW'(NUM_REQ - 1);
         grant_q <= '0;
         ack_q   <= '0;
         op_wr_q <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         op_wr_q <= op_wr_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         re_q    <= re_d;
         busy_q  <= busy_d;
      end
   end

   assign ack       = ack_q;
   assign rdata     = rdata_q;
   assign grant     = grant_q;
   assign busy      = busy_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_we    = we_q;
   assign bus_re    = re_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: directed requests, expected acks queued
// by the stimulus and checked by an independent ack monitor.
module tb_periph_bus_arbiter;

   localparam int N  = 4;
   localparam int AW = 14;
   localparam int DW = 8;
   localparam int RL = 2;

   typedef struct {
      int          idx;
      logic        wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rd;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N-1:0]    req_wr = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]    req_mask = '1;
   logic [N-1:0]    ack;
   logic [DW-1:0]   rdata;
   logic [N-1:0]    grant;
   logic            busy;
   logic [AW-1:0]   bus_addr;
   logic [DW-1:0]   bus_wdata;
   logic            bus_we;
   logic            bus_re;
   logic [DW-1:0]   bus_rdata = 8'hEE;

   int checks = 0;
   int errors = 0;
   exp_t q[$];
   logic [DW-1:0] last_rd = '0;
   logic prev_we = 1'b0;
   int re_cycles = 0;

   periph_bus_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_mask(req_mask), .ack(ack), .rdata(rdata),
      .grant(grant), .busy(busy), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Peripheral model: valid data only once bus_re has been high RL cycles.
   always @(negedge clk) begin
      if (bus_re) re_cycles = re_cycles + 1;
      else re_cycles = 0;
      bus_rdata = (re_cycles >= RL) ? 8'h3C : 8'hEE;
   end

   // Ack monitor: pops the scoreboard on every ack pulse.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         last_rd = '0;
         prev_we = 1'b0;
      end else begin
         if (bus_we) chk("we_single", 32'(prev_we), 32'd0);
         prev_we = bus_we;
         if (|ack) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack act=%b exp=none", ack);
            end else begin
               e = q.pop_front();
               chk("ack", 32'(ack), 32'(1) << e.idx);
               chk("grant", 32'(grant), 32'(1) << e.idx);
               chk("ack_addr", 32'(bus_addr), 32'(e.addr));
               chk("ack_re", 32'(bus_re), 32'd0);
               if (e.wr) begin
                  chk("ack_wdata", 32'(bus_wdata), 32'(e.wdata));
                  chk("rdata_hold", 32'(rdata), 32'(last_rd));
               end else begin
                  chk("rdata", 32'(rdata), 32'(e.rd));
                  last_rd = e.rd;
               end
            end
         end
      end
   end

   task automatic set_req(input int i, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_wr[i] = wr;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic push(input int i, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] rd);
      exp_t e;
      e.idx = i; e.wr = wr; e.addr = a; e.wdata = d; e.rd = rd;
      q.push_back(e);
   endtask

   task automatic push_w(input int i);
      push(i, 1'b1, AW'(256 + i), DW'(16 + i), 8'h00);
   endtask

   task automatic wait_acks(input int n, input logic [N-1:0] dropm);
      int seen = 0;
      int cyc = 0;
      while (seen < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (|ack) begin
            seen++;
            req = req & ~(ack & dropm);
         end
      end
      if (seen < n) chk("ack_timeout", 32'(seen), 32'(n));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ack"}, 32'(ack), 32'd0);
      chk({tag, "_grant"}, 32'(grant), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_we"}, 32'(bus_we), 32'd0);
      chk({tag, "_re"}, 32'(bus_re), 32'd0);
      chk({tag, "_addr"}, 32'(bus_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(bus_wdata), 32'd0);
      chk({tag, "_rdata"}, 32'(rdata), 32'd0);
   endtask

   initial begin
      #1 chk_zero("rst");
      apply_reset();
      chk_zero("rst2");

      // Single write from requester 1.
      set_req(1, 1'b1, 14'h0105, 8'hA5);
      push(1, 1'b1, 14'h0105, 8'hA5, 8'h00);
      req = 4'b0010;
      @(negedge clk);
      chk("w1_grant", 32'(grant), 32'h2);
      chk("w1_we", 32'(bus_we), 32'd1);
      chk("w1_busy", 32'(busy), 32'd1);
      chk("w1_addr", 32'(bus_addr), 32'h0105);
      chk("w1_wdata", 32'(bus_wdata), 32'hA5);
      chk("w1_ack", 32'(ack), 32'd0);
      @(negedge clk);
      chk("w2_ack", 32'(ack), 32'h2);
      chk("w2_we", 32'(bus_we), 32'd0);
      chk("w2_busy", 32'(busy), 32'd1);
      req = '0;
      @(negedge clk);
      chk("w3_busy", 32'(busy), 32'd0);
      chk("w3_grant", 32'(grant), 32'd0);
      chk("w3_addr_hold", 32'(bus_addr), 32'h0105);

      // Single read from requester 0.
      set_req(0, 1'b0, 14'h0003, 8'h00);
      push(0, 1'b0, 14'h0003, 8'h00, 8'h3C);
      req = 4'b0001;
      @(negedge clk);
      chk("r1_re", 32'(bus_re), 32'd1);
      chk("r1_we", 32'(bus_we), 32'd0);
      chk("r1_addr", 32'(bus_addr), 32'h0003);
      @(negedge clk);
      chk("r2_re", 32'(bus_re), 32'd1);
      chk("r2_ack", 32'(ack), 32'd0);
      @(negedge clk);
      chk("r3_ack", 32'(ack), 32'h1);
      chk("r3_rdata", 32'(rdata), 32'h3C);
      req = '0;
      @(negedge clk);
      chk("r4_busy", 32'(busy), 32'd0);

      // Fairness with every requester pending.
      apply_reset();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(256 + i), DW'(16 + i));
      push_w(0); push_w(1); push_w(2); push_w(3); push_w(0); push_w(1);
      req = 4'b1111;
      wait_acks(6, 4'b0000);
      req = '0;
      @(negedge clk);

      // Rotation: last winner 2, then 0 and 3 together.
      push_w(2);
      req = 4'b0100;
      wait_acks(1, 4'b0100);
      @(negedge clk);
      push_w(3); push_w(0);
      req = 4'b1001;
      wait_acks(2, 4'b1001);
      @(negedge clk);

      // Masked requester 1 never wins.
      apply_reset();
      req_mask = 4'b1101;
      push_w(0); push_w(2); push_w(3); push_w(0);
      req = 4'b1111;
      wait_acks(4, 4'b0000);
      req = '0;
      req_mask = 4'b1111;
      @(negedge clk);
      chk("mask_idle", 32'(busy), 32'd0);

      // Async reset in the WAIT cycle of a read abandons it.
      set_req(2, 1'b0, 14'h0222, 8'h00);
      req = 4'b0100;
      repeat (2) @(negedge clk);
      chk("rw_re", 32'(bus_re), 32'd1);
      reset = 1'b0;
      #1 chk_zero("arst");
      repeat (2) @(negedge clk);
      push(2, 1'b0, 14'h0222, 8'h00, 8'h3C);
      reset = 1'b1;
      wait_acks(1, 4'b0100);
      repeat (3) @(negedge clk);

      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
